// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared FSM state type and default sizing for the register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_DEF_DATA_W   = 32;
    localparam int c_DEF_NUM_REGS = 16;
    localparam int c_DEF_NUM_RD   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_multiport_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_multiport_if
// Description : Request/response bundle between a requester and the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = c_DEF_DATA_W,
    parameter int NUM_REGS = c_DEF_NUM_REGS,
    parameter int NUM_RD   = c_DEF_NUM_RD
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                       available;
    logic                       write_en;
    logic [ADDR_W-1:0]          write_addr;
    logic [DATA_W-1:0]          write_data;
    logic [DATA_W/8-1:0]        write_strb;
    logic [NUM_RD*ADDR_W-1:0]   read_addr;
    logic [NUM_RD*DATA_W-1:0]   read_data;
    logic                       busy;

    modport master (
        output available, write_en, write_addr, write_data, write_strb, read_addr,
        input  read_data, busy
    );

    modport slave (
        input  available, write_en, write_addr, write_data, write_strb, read_addr,
        output read_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/regfile_storage.sv
`default_nettype none
// ============================================================================
// Module      : regfile_storage
// Description : Unreset register array with byte-strobed write and one read mux.
//               REGFILE_ZERO_REG_EN makes register 0 a hard-wired zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_storage #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  wire logic                clk,
    input  wire logic                i_we,
    input  wire logic [ADDR_W-1:0]   i_waddr,
    input  wire logic [DATA_W-1:0]   i_wdata,
    input  wire logic [DATA_W/8-1:0] i_wstrb,
    input  wire logic [ADDR_W-1:0]   i_raddr,
    output logic      [DATA_W-1:0]   o_rdata
);

    logic [DATA_W-1:0] w_words [NUM_REGS];

`ifdef REGFILE_ZERO_REG_EN
    localparam int c_FIRST_REG = 1;
    assign w_words[0] = '0;
`else
    localparam int c_FIRST_REG = 0;
`endif

    // Addresses >= NUM_REGS match no generated word, so such writes fall away.
    for (genvar i = c_FIRST_REG; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_W-1:0] r_word;

        always_ff @(posedge clk) begin
            if (i_we && (i_waddr == ADDR_W'(i))) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (i_wstrb[b]) begin
                        r_word[b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end
        end

        assign w_words[i] = r_word;
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_raddr == ADDR_W'(i)) begin
                o_rdata = w_words[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module      : regfile_multiport
// Description : Handshaked register file; reads load one port per cycle via a
//               shared mux. Option macro: REGFILE_ZERO_REG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = c_DEF_DATA_W,
    parameter int NUM_REGS = c_DEF_NUM_REGS,
    parameter int NUM_RD   = c_DEF_NUM_RD
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    regfile_multiport_if.slave bus
);

    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int IDX_W  = $clog2(NUM_RD + 1);

    state_t                   r_state;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_busy;
    logic [NUM_RD*DATA_W-1:0] r_read_data;

    logic [IDX_W-1:0]         w_sel;
    logic [ADDR_W-1:0]        w_rd_addr;
    logic [DATA_W-1:0]        w_rd_word;
    logic                     w_we;

    assign w_we  = (r_state == START) && bus.write_en;
    assign w_sel = (r_state == READ) ? r_idx : '0;

    always_comb begin
        w_rd_addr = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (w_sel == IDX_W'(k)) begin
                w_rd_addr = bus.read_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    regfile_storage #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_storage (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (bus.write_addr),
        .i_wdata (bus.write_data),
        .i_wstrb (bus.write_strb),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_read_data <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.available) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                START: begin
                    if (bus.write_en) begin
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_read_data[DATA_W-1:0] <= w_rd_word;
                        r_idx <= IDX_W'(1);
                        if (NUM_RD == 1) begin
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                READ: begin
                    // Ports above the index keep their old value until reached.
                    for (int k = 1; k < NUM_RD; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            r_read_data[k*DATA_W +: DATA_W] <= w_rd_word;
                        end
                    end
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(NUM_RD - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.available) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.read_data = r_read_data;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_multiport
// Description : Scoreboarded bench for a default 32x16x2 and a 16x12x4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_multiport;
    import regfile_pkg::*;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;
    logic [63:0] sb_q [$];
    logic [31:0] exp_r0;

    regfile_multiport_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(2)) bus_a ();
    regfile_multiport_if #(.DATA_W(16), .NUM_REGS(12), .NUM_RD(4)) bus_b ();

    regfile_multiport #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(2)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    regfile_multiport #(.DATA_W(16), .NUM_REGS(12), .NUM_RD(4)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at posedge+1 with the DUT idle; returns the number of busy cycles.
    task automatic op_a(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [7:0] ra, output int cycles);
        bus_a.available  = 1'b1;
        bus_a.write_en   = we;
        bus_a.write_addr = wa;
        bus_a.write_data = wd;
        bus_a.write_strb = ws;
        bus_a.read_addr  = ra;
        cycles = 0;
        @(posedge clk); #1;
        while (bus_a.busy === 1'b1 && cycles < 20) begin
            cycles++;
            @(posedge clk); #1;
        end
        bus_a.available = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic op_b(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic [1:0] ws, input logic [15:0] ra, output int cycles);
        bus_b.available  = 1'b1;
        bus_b.write_en   = we;
        bus_b.write_addr = wa;
        bus_b.write_data = wd;
        bus_b.write_strb = ws;
        bus_b.read_addr  = ra;
        cycles = 0;
        @(posedge clk); #1;
        while (bus_b.busy === 1'b1 && cycles < 20) begin
            cycles++;
            @(posedge clk); #1;
        end
        bus_b.available = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_a got=%b exp=0", bus_a.busy); end
        n_vec++;
        if (bus_a.read_data !== 64'h0) begin n_err++; $display("FAIL reset_rdata_a got=%h exp=0", bus_a.read_data); end
        n_vec++;
        if (bus_b.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_b got=%b exp=0", bus_b.busy); end
        n_vec++;
        if (bus_b.read_data !== 64'h0) begin n_err++; $display("FAIL reset_rdata_b got=%h exp=0", bus_b.read_data); end
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int cyc;
        logic [63:0] exp;
        op_a(1'b1, 4'd0, 32'h1234_5678, 4'hF, 8'h00, cyc);
        n_vec++;
        if (cyc != 1) begin n_err++; $display("FAIL wr_r0_busy got=%0d exp=1", cyc); end
        op_a(1'b1, 4'd5, 32'hDEAD_BEEF, 4'hF, 8'h00, cyc);
        n_vec++;
        if (cyc != 1) begin n_err++; $display("FAIL wr_r5_busy got=%0d exp=1", cyc); end
        sb_q.push_back({exp_r0, 32'hDEAD_BEEF});
        op_a(1'b0, 4'd0, 32'h0, 4'h0, {4'd0, 4'd5}, cyc);
        n_vec++;
        if (cyc != 2) begin n_err++; $display("FAIL rd_50_busy got=%0d exp=2", cyc); end
        exp = sb_q.pop_front();
        n_vec++;
        if (bus_a.read_data !== exp) begin n_err++; $display("FAIL rd_50_data got=%h exp=%h", bus_a.read_data, exp); end
    endtask

    task automatic test_byte_strobe();
        int cyc;
        logic [63:0] exp;
        op_a(1'b1, 4'd3, 32'h1122_3344, 4'hF, 8'h00, cyc);
        op_a(1'b1, 4'd3, 32'hAABB_CCDD, 4'b0101, 8'h00, cyc);
        n_vec++;
        if (cyc != 1) begin n_err++; $display("FAIL strb_wr_busy got=%0d exp=1", cyc); end
        sb_q.push_back({32'h11BB_33DD, 32'h11BB_33DD});
        op_a(1'b0, 4'd0, 32'h0, 4'h0, {4'd3, 4'd3}, cyc);
        exp = sb_q.pop_front();
        n_vec++;
        if (bus_a.read_data !== exp) begin n_err++; $display("FAIL strb_rd_data got=%h exp=%h", bus_a.read_data, exp); end
        // All-zero strobe still handshakes but leaves r3 alone.
        op_a(1'b1, 4'd3, 32'hFFFF_FFFF, 4'h0, 8'h00, cyc);
        n_vec++;
        if (cyc != 1) begin n_err++; $display("FAIL zstrb_busy got=%0d exp=1", cyc); end
        sb_q.push_back({32'hDEAD_BEEF, 32'h11BB_33DD});
        op_a(1'b0, 4'd0, 32'h0, 4'h0, {4'd5, 4'd3}, cyc);
        exp = sb_q.pop_front();
        n_vec++;
        if (bus_a.read_data !== exp) begin n_err++; $display("FAIL zstrb_rd_data got=%h exp=%h", bus_a.read_data, exp); end
    endtask

    task automatic test_wide_read();
        int cyc;
        logic [63:0] exp;
        op_b(1'b1, 4'd1, 16'h1111, 2'b11, 16'h0, cyc);
        op_b(1'b1, 4'd2, 16'h2222, 2'b11, 16'h0, cyc);
        op_b(1'b1, 4'd11, 16'hBBBB, 2'b11, 16'h0, cyc);
        op_b(1'b1, 4'd13, 16'hDDDD, 2'b11, 16'h0, cyc);
        n_vec++;
        if (cyc != 1) begin n_err++; $display("FAIL wr13_busy got=%0d exp=1", cyc); end
        sb_q.push_back({16'hBBBB, 16'h0000, 16'h2222, 16'h1111});
        op_b(1'b0, 4'd0, 16'h0, 2'b00, {4'd11, 4'd13, 4'd2, 4'd1}, cyc);
        n_vec++;
        if (cyc != 4) begin n_err++; $display("FAIL wide_rd_busy got=%0d exp=4", cyc); end
        exp = sb_q.pop_front();
        n_vec++;
        if (bus_b.read_data !== exp) begin n_err++; $display("FAIL wide_rd_data got=%h exp=%h", bus_b.read_data, exp); end
    endtask

    task automatic test_reset_mid_read();
        int cyc;
        logic [63:0] exp;
        bus_b.available = 1'b1;
        bus_b.write_en  = 1'b0;
        bus_b.read_addr = {4'd1, 4'd2, 4'd11, 4'd1};
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (dut_b.r_state !== READ || dut_b.r_idx !== 3'd1) begin
            n_err++; $display("FAIL mid_rd_state got=%0d/%0d exp=READ/1", dut_b.r_state, dut_b.r_idx);
        end
        #1 reset_n = 1'b0;
        #1;
        n_vec++;
        if (bus_b.busy !== 1'b0) begin n_err++; $display("FAIL async_rst_busy got=%b exp=0", bus_b.busy); end
        n_vec++;
        if (bus_b.read_data !== 64'h0) begin n_err++; $display("FAIL async_rst_data got=%h exp=0", bus_b.read_data); end
        n_vec++;
        if (dut_b.r_state !== IDLE) begin n_err++; $display("FAIL async_rst_state got=%0d exp=IDLE", dut_b.r_state); end
        bus_b.available = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        sb_q.push_back({16'h1111, 16'h2222, 16'hBBBB, 16'h1111});
        op_b(1'b0, 4'd0, 16'h0, 2'b00, {4'd1, 4'd2, 4'd11, 4'd1}, cyc);
        n_vec++;
        if (cyc != 4) begin n_err++; $display("FAIL post_rst_busy got=%0d exp=4", cyc); end
        exp = sb_q.pop_front();
        n_vec++;
        if (bus_b.read_data !== exp) begin n_err++; $display("FAIL post_rst_data got=%h exp=%h", bus_b.read_data, exp); end
    endtask

    task automatic test_held_available();
        int bad;
        bus_a.available  = 1'b1;
        bus_a.write_en   = 1'b1;
        bus_a.write_addr = 4'd7;
        bus_a.write_data = 32'h0000_0077;
        bus_a.write_strb = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL held_wr_done got=%b exp=0", bus_a.busy); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus_a.busy !== 1'b0 || dut_a.r_state !== DONE) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL held_stay_done got=%0d bad cycles exp=0", bad); end
        bus_a.available = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (dut_a.r_state !== IDLE) begin n_err++; $display("FAIL held_to_idle got=%0d exp=IDLE", dut_a.r_state); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
`ifdef REGFILE_ZERO_REG_EN
        exp_r0 = 32'h0;
`else
        exp_r0 = 32'h1234_5678;
`endif
        reset_n = 1'b0;
        bus_a.available = 1'b0; bus_a.write_en = 1'b0; bus_a.write_addr = '0;
        bus_a.write_data = '0;  bus_a.write_strb = '0; bus_a.read_addr = '0;
        bus_b.available = 1'b0; bus_b.write_en = 1'b0; bus_b.write_addr = '0;
        bus_b.write_data = '0;  bus_b.write_strb = '0; bus_b.read_addr = '0;
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_wide_read();
        test_reset_mid_read();
        test_held_available();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits; multiple of 8.
REQ-002 SHALL have parameter NUM_REGS, default 16: register count, at least 2; localparam ADDR_W = $clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2: read port count, at least 1.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port available, input, 1: operation request; held high until busy falls.
REQ-007 SHALL have port write_en, input, 1: 1 = write operation, 0 = read operation.
REQ-008 SHALL have port write_addr, input, ADDR_W: write target.
REQ-009 SHALL have port write_data, input, DATA_W: write value.
REQ-010 SHALL have port write_strb, input, DATA_W/8: per-byte write enables.
REQ-011 SHALL have port read_addr, input, NUM_RD*ADDR_W: packed read addresses; port k at [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port read_data, output, NUM_RD*DATA_W: packed registered read results, same packing.
REQ-013 SHALL have port busy, output, 1: operation in progress.

Function
REQ-014 SHALL implement FSM states IDLE, START, READ, DONE, plus a read index counter of width $clog2(NUM_RD+1).
REQ-015 IDLE with available=1 SHALL go to START and set busy=1 on the next edge; otherwise stay in IDLE.
REQ-016 START with write_en=1 SHALL perform the write, clear busy and go to DONE on the same edge; write latency is 2 edges after request.
REQ-017 A write SHALL update byte i of the target only where write_strb[i]=1; all-zero strobe completes the handshake with no change.
REQ-018 START with write_en=0 SHALL load read_data port 0 and set index=1; it SHALL go to READ, or to DONE with busy=0 when NUM_RD=1.
REQ-019 READ SHALL load read_data port index, one port per cycle through a single shared read mux, then increment the index.
REQ-020 On loading port NUM_RD-1, READ SHALL clear busy and go to DONE; read latency is NUM_RD+1 edges after request.
REQ-021 During a read, ports not yet loaded SHALL hold their previous values.
REQ-022 DONE SHALL stay while available=1 and go to IDLE when available=0; no new operation starts until IDLE is re-entered.
REQ-023 A write address >= NUM_REGS SHALL be ignored; a read of such an address SHALL return 0.
REQ-024 Inputs SHALL be sampled in each cycle they are consumed; stability while available=1 is a caller obligation.
REQ-025 If available drops mid-operation, the block SHALL finish the operation, then pass through DONE to IDLE.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately force state IDLE, busy=0, index=0 and all read_data=0, including mid-operation.
REQ-027 Register storage SHALL NOT be reset; contents after reset are undefined except where REQ-028 applies.

Configuration
REQ-028 With REGFILE_ZERO_REG_EN defined, register 0 SHALL have no storage, reads of address 0 SHALL return 0, and writes to address 0 SHALL be discarded.
REQ-029 Without REGFILE_ZERO_REG_EN, register 0 SHALL be ordinary storage.

Structure
REQ-030 Package regfile_pkg SHALL hold the FSM state enum typedef and default parameter constants.
REQ-031 Storage with strobed write and single read mux SHALL be sub-module regfile_storage; regfile_multiport holds the FSM, index counter and output registers.

Verification
REQ-032 Bench SHALL cover write then read: write r5=0xDEADBEEF with strb 0xF, then read ports (5,0) -> busy high 1 cycle for the write and 2 cycles for the read; read_data = {0x00000000 (ZERO_REG_EN), 0xDEADBEEF}.
REQ-033 Bench SHALL cover byte strobe: r3=0x11223344, then write 0xAABBCCDD with strb 0b0101 -> reading r3 returns 0x11BB33DD.
REQ-034 Bench SHALL cover NUM_RD=4, DATA_W=16, NUM_REGS=12: read addrs (1,2,13,11) -> 4 busy cycles; port 2 reads 0; a write to 13 changes nothing.
REQ-035 Bench SHALL cover reset mid-read: assert reset_n in READ with index 1 -> busy=0 and read_data=0 asynchronously; the next request starts from IDLE.
REQ-036 Bench SHALL cover held available: keep available=1 for 5 cycles after busy falls -> FSM stays in DONE, no second operation; available low -> IDLE next edge.
